// File: rtl/op_select_controller.sv
// op_select_controller: menu-driven sequencer for the calculator operation
// modules. It scrolls an operation menu, clears the chosen module, and then
// runs it alone. While the module runs, its text is shown and button pulses
// are forwarded to it. Control returns to the menu on done or abort.
module op_select_controller #(
  parameter int TEXT_W = 257,
  parameter int N_OPS  = 4
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              btn_next,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_back,
  input  logic [N_OPS-1:0]  mod_done,
  input  logic [TEXT_W-1:0] mod_text0,
  input  logic [TEXT_W-1:0] mod_text1,
  input  logic [TEXT_W-1:0] mod_text2,
  input  logic [TEXT_W-1:0] mod_text3,
  output logic [N_OPS-1:0]  mod_enable,
  output logic [N_OPS-1:0]  mod_next,
  output logic [N_OPS-1:0]  mod_reset,
  output logic [TEXT_W-1:0] textOut,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [7:0]        op_count
);

  typedef enum logic [3:0] {
    MENU     = 4'b0001,
    ARM      = 4'b0010,
    RUN      = 4'b0100,
    FINISHED = 4'b1000
  } state_t;

  state_t state, state_n;

  logic [N_OPS-1:0][TEXT_W-1:0] mod_text_a;
  logic [N_OPS-1:0]             sel_oh;
  logic [1:0]                   sel_n;
  logic [7:0]                   cnt_n;
  logic [TEXT_W-1:0]            text_n;
  logic [N_OPS-1:0]             enable_d, next_d, mreset_d;
  logic                         busy_d;

  assign mod_text_a[0] = mod_text0;
  assign mod_text_a[1] = mod_text1;
  assign mod_text_a[2] = mod_text2;
  assign mod_text_a[3] = mod_text3;

  assign sel_oh = {{(N_OPS-1){1'b0}}, 1'b1} << sel;

  // Menu screen: fixed header line, padded operation name on the second line.
  // The top text bit stays 0 for menu content.
  function automatic logic [TEXT_W-1:0] menu_text(input logic [1:0] s);
    logic [127:0] nm;
    logic [255:0] full;
    case (s)
      2'd0:    nm = {"Add",      {13{8'h20}}};
      2'd1:    nm = {"Subtract", {8{8'h20}}};
      2'd2:    nm = {"Multiply", {8{8'h20}}};
      default: nm = {"Divide",   {10{8'h20}}};
    endcase
    full = {"Select Op:", {6{8'h20}}, nm};
    return TEXT_W'(full);
  endfunction

  // State register
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state <= MENU;
    else       state <= state_n;
  end

  // Next state and next values of all registered outputs
  always_comb begin
    state_n  = state;
    sel_n    = sel;
    cnt_n    = op_count;
    text_n   = textOut;
    next_d   = '0;
    mreset_d = '0;
    case (state)
      MENU: begin
        // select wins over scrolling; up+down together cancel
        if (btn_next) begin
          state_n  = ARM;
          mreset_d = sel_oh;
        end else if (btn_up && !btn_down) begin
          sel_n = sel + 2'd1;
        end else if (btn_down && !btn_up) begin
          sel_n = sel - 2'd1;
        end
        text_n = menu_text(sel_n);
      end
      ARM: state_n = RUN;
      RUN: begin
        text_n = mod_text_a[sel];
        if (btn_next) next_d = sel_oh;
        // done beats abort when both arrive together
        if (mod_done[sel]) begin
          state_n = FINISHED;
          if (op_count != 8'hFF) cnt_n = op_count + 8'd1;
        end else if (btn_back) begin
          state_n  = MENU;
          mreset_d = sel_oh;
        end
      end
      FINISHED: begin
        text_n = mod_text_a[sel];
        if (btn_next || btn_back) state_n = MENU;
      end
      default: state_n = MENU;
    endcase
    enable_d = (state_n == RUN || state_n == FINISHED) ? sel_oh : '0;
    busy_d   = (state_n != MENU);
  end

  // Registered outputs
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      sel        <= 2'd0;
      mod_enable <= '0;
      mod_next   <= '0;
      mod_reset  <= '0;
      busy       <= 1'b0;
      op_count   <= 8'd0;
      textOut    <= '0;
    end else begin
      sel        <= sel_n;
      mod_enable <= enable_d;
      mod_next   <= next_d;
      mod_reset  <= mreset_d;
      busy       <= busy_d;
      op_count   <= cnt_n;
      textOut    <= text_n;
    end
  end

endmodule

// File: tb/tb_op_select_controller.sv
// tb_op_select_controller: directed stimulus, a transaction-level model of
// the menu/run sequencer checked every cycle, and literal spot checks.
module tb_op_select_controller;
  localparam int TW = 257;

  logic          Clk = 1'b0, reset = 1'b1;
  logic          btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_back = 1'b0;
  logic [3:0]    mod_done = 4'b0;
  logic [TW-1:0] mtext [4];
  logic [3:0]    mod_enable, mod_next, mod_reset;
  logic [TW-1:0] textOut;
  logic [1:0]    sel;
  logic          busy;
  logic [7:0]    op_count;

  int n_chk = 0, n_fail = 0;

  op_select_controller #(.TEXT_W(TW), .N_OPS(4)) dut (
    .Clk(Clk), .reset(reset),
    .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down), .btn_back(btn_back),
    .mod_done(mod_done),
    .mod_text0(mtext[0]), .mod_text1(mtext[1]), .mod_text2(mtext[2]), .mod_text3(mtext[3]),
    .mod_enable(mod_enable), .mod_next(mod_next), .mod_reset(mod_reset),
    .textOut(textOut), .sel(sel), .busy(busy), .op_count(op_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] rand_text();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
    return t[TW-1:0];
  endfunction

  // Screen text built character by character from the plain names
  function automatic logic [TW-1:0] menu_bits(input int s);
    string hdr, nm;
    logic [TW-1:0] r;
    byte c;
    hdr = "Select Op:";
    case (s)
      0: nm = "Add";
      1: nm = "Subtract";
      2: nm = "Multiply";
      default: nm = "Divide";
    endcase
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < 16) c = (i < hdr.len()) ? hdr[i] : 8'h20;
      else        c = (i - 16 < nm.len()) ? nm[i-16] : 8'h20;
      r[255 - 8*i -: 8] = c;
    end
    return r;
  endfunction

  // Reference model: 0 menu, 1 arming, 2 running, 3 showing result
  int            m_phase = 0, m_sel = 0, m_count = 0;
  logic [3:0]    e_en = 0, e_nx = 0, e_rs = 0;
  logic [TW-1:0] e_text = '0;
  logic          e_busy = 0;

  always @(posedge Clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_sel = 0; m_count = 0;
      e_en = 0; e_nx = 0; e_rs = 0; e_text = '0; e_busy = 0;
    end else begin
      e_nx = 0; e_rs = 0;
      case (m_phase)
        0: begin
          if (btn_next) begin m_phase = 1; e_rs = 4'(1 << m_sel); end
          else if (btn_up && !btn_down) m_sel = (m_sel + 1) % 4;
          else if (btn_down && !btn_up) m_sel = (m_sel + 3) % 4;
          e_text = menu_bits(m_sel);
        end
        1: m_phase = 2;
        2: begin
          e_text = mtext[m_sel];
          if (btn_next) e_nx = 4'(1 << m_sel);
          if (mod_done[m_sel]) begin
            m_phase = 3;
            if (m_count < 255) m_count++;
          end else if (btn_back) begin
            m_phase = 0; e_rs = 4'(1 << m_sel);
          end
        end
        default: begin
          e_text = mtext[m_sel];
          if (btn_next || btn_back) m_phase = 0;
        end
      endcase
      e_en   = (m_phase >= 2) ? 4'(1 << m_sel) : 4'b0;
      e_busy = (m_phase != 0);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge Clk) begin
    if (!reset) begin
      chk("mod_enable", TW'(mod_enable), TW'(e_en));
      chk("mod_next",   TW'(mod_next),   TW'(e_nx));
      chk("mod_reset",  TW'(mod_reset),  TW'(e_rs));
      chk("textOut",    textOut,         e_text);
      chk("sel",        TW'(sel),        TW'(m_sel));
      chk("busy",       TW'(busy),       TW'(e_busy));
      chk("op_count",   TW'(op_count),   TW'(m_count));
    end
  end

  task automatic tick(input logic n, input logic u, input logic d, input logic b);
    btn_next = n; btn_up = u; btn_down = d; btn_back = b;
    @(posedge Clk); #1;
    btn_next = 0; btn_up = 0; btn_down = 0; btn_back = 0;
  endtask

  initial begin
    logic [TW-1:0] pad128;
    for (int i = 0; i < 4; i++) mtext[i] = rand_text();

    repeat (2) @(posedge Clk);
    @(negedge Clk); reset = 0; #1;
    chk("rst_text",  textOut, '0);
    chk("rst_state", TW'({sel, busy, op_count, mod_enable, mod_next, mod_reset}), '0);

    tick(0, 0, 0, 0);
    pad128 = TW'({"Add", {13{8'h20}}});
    chk("menu_add", TW'(textOut[127:0]), pad128);

    repeat (5) tick(0, 1, 0, 0);
    chk("sel_up5", TW'(sel), TW'(2'd1));
    pad128 = TW'({"Subtract", {8{8'h20}}});
    chk("menu_sub", TW'(textOut[127:0]), pad128);
    pad128 = TW'({"Select Op:", {6{8'h20}}});
    chk("menu_hdr", TW'(textOut[255:128]), pad128);
    repeat (2) tick(0, 0, 1, 0);
    chk("sel_wrap", TW'(sel), TW'(2'd3));
    tick(0, 1, 1, 0);
    chk("sel_both", TW'(sel), TW'(2'd3));

    // select Divide
    tick(1, 0, 0, 0);
    chk("arm_reset", TW'(mod_reset), TW'(4'b1000));
    chk("arm_en",    TW'(mod_enable), '0);
    tick(0, 0, 0, 0);
    chk("run_reset", TW'(mod_reset), '0);
    chk("run_en",    TW'(mod_enable), TW'(4'b1000));
    tick(0, 0, 0, 0);
    chk("run_text",  textOut, mtext[3]);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0);
      chk("fwd_next", TW'(mod_next), TW'(4'b1000));
    end
    tick(0, 0, 0, 0);
    chk("fwd_idle", TW'(mod_next), '0);

    // completion
    mod_done = 4'b1000;
    tick(0, 0, 0, 0);
    chk("done_cnt",  TW'(op_count), TW'(8'd1));
    chk("done_busy", TW'(busy), TW'(1'b1));
    mtext[3] = rand_text();
    tick(0, 0, 0, 0);
    chk("fin_text", textOut, mtext[3]);
    mod_done = 4'b0;
    tick(1, 0, 0, 0);
    chk("fin_next", TW'({mod_next, mod_enable, mod_reset, busy}), '0);

    // abort
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    chk("abort_rst", TW'(mod_reset), TW'(4'b1000));
    chk("abort_cnt", TW'(op_count), TW'(8'd1));
    chk("abort_en",  TW'(mod_enable), '0);
    tick(0, 0, 0, 0);

    // back and done together: done wins
    tick(1, 0, 0, 0); tick(0, 0, 0, 0);
    mod_done = 4'b1000;
    tick(0, 0, 0, 1);
    chk("both_busy", TW'(busy), TW'(1'b1));
    chk("both_cnt",  TW'(op_count), TW'(8'd2));
    mod_done = 4'b0;
    tick(0, 0, 0, 1);

    // foreign done ignored while Multiply runs
    tick(0, 0, 1, 0);
    mod_done = 4'b0001;
    tick(1, 0, 0, 0); tick(0, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    chk("foreign_busy", TW'(busy), TW'(1'b1));
    chk("foreign_cnt",  TW'(op_count), TW'(8'd2));
    mod_done = 4'b0;

    // saturation
    for (int i = 0; i < 256; i++) begin
      mod_done = 4'b0100;
      tick(0, 0, 0, 0);
      mod_done = 4'b0;
      tick(1, 0, 0, 0); tick(1, 0, 0, 0); tick(0, 0, 0, 0);
      if (i % 16 == 0) mtext[2] = rand_text();
    end
    chk("sat_cnt", TW'(op_count), TW'(8'd255));

    // asynchronous reset mid-run
    tick(1, 0, 0, 0);
    chk("pre_rst_next", TW'(mod_next), TW'(4'b0100));
    #2 reset = 1; #1;
    chk("arst_out", TW'({sel, busy, op_count, mod_enable, mod_next, mod_reset}), '0);
    chk("arst_text", textOut, '0);
    @(negedge Clk); reset = 0;
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/op_select_controller.md
# op_select_controller

Top-level sequencer for the calculator operation modules (add, subtract, multiply, divide). It presents a scrollable operation menu on the LCD and clears the selected module into its start state. It then enables that module alone and forwards only to it the single-cycle button pulses. It multiplexes the module's 32-character text onto the LCD bus and returns to the menu when the module reports done or the user aborts.

## Interface
Parameters:
- TEXT_W, 257, width of every LCD text bus (32 chars × 8 bits + 1; bit 256 always 0 when driven from the menu)
- N_OPS, 4, number of operation modules; fixed at 4 in this revision

Ports:
- Clk  input  1  system clock; all state changes on posedge
- reset  input  1  asynchronous, active-high; one clock domain only
- btn_next  input  1  single-cycle pulse (debounced BtnC): select / advance
- btn_up  input  1  single-cycle pulse: next menu entry
- btn_down  input  1  single-cycle pulse: previous menu entry
- btn_back  input  1  single-cycle pulse: abort or leave result screen
- mod_done  input  4  done flag from module i (level, held high)
- mod_text0..mod_text3  input  TEXT_W each  text bus from module i
- mod_enable  output  4  one-hot enable to selected module, registered
- mod_next  output  4  forwarded next pulse, registered, at most one bit high
- mod_reset  output  4  registered clear pulse to module i
- textOut  output  TEXT_W  LCD text, registered
- sel  output  2  current menu index
- busy  output  1  high in ARM, RUN, FINISHED
- op_count  output  8  completed-operation count, saturating

## Operation
- States: MENU, ARM, RUN, FINISHED (one-hot, 4 bits).
- Reset values: state=MENU, sel=0, mod_enable=0, mod_next=0, mod_reset=0, busy=0, op_count=0, textOut=0. The first MENU cycle loads the menu string.
- MENU:
  - textOut = "Select Op:      " followed by the padded name for sel: "Add             ", "Subtract        ", "Multiply        ", "Divide          ".
  - btn_up alone → sel+1 mod 4 (3→0). btn_down alone → sel−1 mod 4 (0→3). btn_up and btn_down together → no change.
  - btn_next → ARM. btn_next has priority over up/down in the same cycle; sel is unchanged.
  - btn_back is ignored.
- ARM, exactly 1 cycle: mod_reset[sel]=1, mod_enable=0, then → RUN. This clears stale done and data from any prior run.
- RUN:
  - mod_enable[sel]=1 and textOut = mod_text[sel].
  - btn_next → mod_next[sel]=1 on the following cycle.
  - mod_done[sel]=1 → FINISHED, and op_count increments, saturating at 255.
  - btn_back → MENU. mod_reset[sel] pulses for 1 cycle on entry to MENU, and mod_enable clears.
  - btn_back and mod_done in the same cycle → FINISHED; done wins and the count increments.
  - mod_done of non-selected modules is ignored.
- FINISHED:
  - mod_enable[sel] stays high and textOut = mod_text[sel], so the result stays visible.
  - btn_next is not forwarded. btn_next or btn_back → MENU with no mod_reset; the module is cleared at its next ARM.
- sel is frozen outside MENU. Up/down pulses are ignored in ARM, RUN and FINISHED.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously), including mod_enable=0. The modules are reset by the global reset separately.

## Timing
- All outputs are registered; inputs are sampled at posedge Clk.
- Menu button to new menu text: 1 cycle.
- btn_next in MENU at edge t:
  - state=ARM and mod_reset[sel]=1 after edge t.
  - RUN and mod_enable[sel]=1 after edge t+1.
  - Module text visible after edge t+2.
- RUN forwarding: btn_next sampled at edge t → mod_next[sel] high for exactly the cycle after edge t. Back-to-back pulses forward back-to-back.
- Done detection: mod_done[sel] sampled at edge t → state=FINISHED and op_count updated after edge t.
- textOut tracks mod_text[sel] with 1-cycle latency in RUN and FINISHED.

## Test plan
- Reset, then 5× btn_up → sel=1 and text ends "Subtract        ". Then 2× btn_down → sel=3 (wrap 0→3). Then btn_up and btn_down in the same cycle → sel stays 3.
- sel=3, btn_next at t → mod_reset=4'b1000 for exactly 1 cycle, then mod_enable=4'b1000. Then btn_next ×3 → mod_next=4'b1000 three single cycles, each 1 cycle after its button.
- In RUN, raise mod_done[3] → FINISHED, op_count=1, textOut equals mod_text3. A btn_next then yields no mod_next pulse, state=MENU, mod_enable=0.
- In RUN, btn_back → MENU, mod_reset[sel] pulses once, op_count unchanged. btn_back and mod_done together → FINISHED with op_count+1.
- mod_done[0]=1 held while sel=2 is running → no transition. Reach 256 completions → op_count saturates at 255.
- Assert reset during RUN → mod_enable=0, mod_next=0, state=MENU, sel=0 without waiting for a clock edge.
